// File: rtl/game_timer_display.sv
// HUD run timer: cascaded BCD up/down counter with
// frame-coherent snapshot and font ROM addressing.
module game_timer_display #(
  parameter int CLK_DIV     = 10000000,
  parameter int NUM_DIGITS  = 4,
  parameter int FRAC_DIGITS = 1,
  parameter int ROW         = 1,
  parameter int COL0        = 0
) (
  input  logic                    clk,
  input  logic                    reset_game,
  input  logic                    pause,
  input  logic                    count_down,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    frame_tick,
  input  logic [9:0]              pixel_x,
  input  logic [9:0]              pixel_y,
  output logic                    time_on,
  output logic [2:0]              time_bit_addr,
  output logic [10:0]             time_rom_addr,
  output logic                    second_tick,
  output logic                    expired
);

  localparam int PW    = $clog2(CLK_DIV);
  localparam int HASDP = (FRAC_DIGITS > 0) ? 1 : 0;
  localparam int NCHAR = NUM_DIGITS + HASDP;
  localparam int DP    = NUM_DIGITS - FRAC_DIGITS;

  typedef logic [NUM_DIGITS-1:0][3:0] bcd_t;

  logic [PW-1:0] presc;
  logic          down_q;
  bcd_t          dig;
  bcd_t          dig_nxt;
  bcd_t          snap;
  bcd_t          load_clamp;
  logic          run;
  logic          tick;
  logic          at_term;
  logic          carry;
  logic          frac_chg;

  assign run  = !pause && !expired;
  assign tick = run && (presc == PW'(CLK_DIV - 1));

  always_comb begin
    load_clamp = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (load_value[4*i+:4] > 4'd9)
        load_clamp[i] = 4'd9;
      else
        load_clamp[i] = load_value[4*i+:4];
    end
  end

  always_comb begin
    at_term = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (down_q ? (dig[i] != 4'd0)
                 : (dig[i] != 4'd9))
        at_term = 1'b0;
    end
  end

  // Ripple carry/borrow through the digit chain
  always_comb begin
    dig_nxt = dig;
    carry   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (!down_q) begin
          if (dig[i] == 4'd9) begin
            dig_nxt[i] = 4'd0;
          end else begin
            dig_nxt[i] = dig[i] + 4'd1;
            carry      = 1'b0;
          end
        end else begin
          if (dig[i] == 4'd0) begin
            dig_nxt[i] = 4'd9;
          end else begin
            dig_nxt[i] = dig[i] - 4'd1;
            carry      = 1'b0;
          end
        end
      end
    end
  end

  assign frac_chg = dig_nxt[FRAC_DIGITS]
                    != dig[FRAC_DIGITS];

  always_ff @(posedge clk) begin
    if (reset_game) begin
      presc       <= '0;
      second_tick <= 1'b0;
      expired     <= 1'b0;
      down_q      <= count_down;
      dig         <= count_down ? load_clamp : '0;
      snap        <= count_down ? load_clamp : '0;
    end else begin
      second_tick <= tick && !at_term && frac_chg;
      if (run)
        presc <= tick ? '0 : presc + PW'(1);
      if (tick && !at_term)
        dig <= dig_nxt;
      expired <= expired | at_term;
      if (frame_tick)
        snap <= dig;
    end
  end

  function automatic int pos_of(int k);
    return NUM_DIGITS - 1 - k
           + ((k < FRAC_DIGITS) ? 1 : 0);
  endfunction

  logic [5:0] col;
  logic [5:0] idx;
  logic [6:0] ch;
  logic       unused_lsb;

  assign col = pixel_x[9:4];
  assign idx = col - 6'(COL0);
  assign unused_lsb = ^{pixel_x[0], pixel_y[0]};

  assign time_on = (pixel_y[9:5] == 5'(ROW))
                && (col >= 6'(COL0))
                && (idx < 6'(NCHAR));

  always_comb begin
    ch = 7'h00;
    if (time_on) begin
      if (HASDP == 1 && idx == 6'(DP))
        ch = 7'h2E;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx == 6'(pos_of(k)))
          ch = {3'b011, snap[k]};
      end
    end
  end

  assign time_bit_addr = pixel_x[3:1];
  assign time_rom_addr = {ch, pixel_y[4:1]};

endmodule

// File: tb/tb_game_timer_display.sv
// Directed scoreboard bench for game_timer_display.
// Digits are observed through the snapshot/ROM path.
module tb_game_timer_display;

  logic        clk = 1'b0;
  logic        reset_game = 1'b0;
  logic        pause = 1'b0;
  logic        count_down = 1'b0;
  logic [15:0] load_value = '0;
  logic        frame_tick = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic        time_on;
  logic [2:0]  time_bit_addr;
  logic [10:0] time_rom_addr;
  logic        second_tick;
  logic        expired;

  logic        rst2 = 1'b1;
  logic        cd2 = 1'b0;
  logic [7:0]  load2 = '0;
  logic        on2;
  logic [2:0]  bit2;
  logic [10:0] rom2;
  logic        st2;
  logic        exp2;

  int ncmp  = 0;
  int nfail = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #10 clk = ~clk;

  game_timer_display #(
    .CLK_DIV(4), .NUM_DIGITS(4), .FRAC_DIGITS(1),
    .ROW(1), .COL0(0)
  ) u1 (
    .clk(clk), .reset_game(reset_game),
    .pause(pause), .count_down(count_down),
    .load_value(load_value),
    .frame_tick(frame_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .time_on(time_on),
    .time_bit_addr(time_bit_addr),
    .time_rom_addr(time_rom_addr),
    .second_tick(second_tick),
    .expired(expired)
  );

  game_timer_display #(
    .CLK_DIV(2), .NUM_DIGITS(2), .FRAC_DIGITS(0),
    .ROW(1), .COL0(0)
  ) u2 (
    .clk(clk), .reset_game(rst2),
    .pause(pause), .count_down(cd2),
    .load_value(load2),
    .frame_tick(frame_tick),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .time_on(on2),
    .time_bit_addr(bit2),
    .time_rom_addr(rom2),
    .second_tick(st2),
    .expired(exp2)
  );

  task automatic push(string t, logic [31:0] e);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic pop_cmp(logic [31:0] obs);
    logic [31:0] e;
    string t;
    ncmp++;
    if (exp_q.size() == 0) begin
      nfail++;
      $display("FAIL scoreboard_empty observed %0h", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        nfail++;
        $error("FAIL %s: observed %0h expected %0h",
               t, obs, e);
      end
    end
  endtask

  task automatic nclk(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_game = 1'b1;
    @(negedge clk);
    reset_game = 1'b0;
  endtask

  // Reads the 4-digit snapshot of u1 via the ROM address
  task automatic read_bcd(output logic [15:0] v);
    logic [6:0] c;
    int d;
    v = '0;
    d = 3;
    pixel_y = 10'd40;
    for (int i = 0; i < 5; i++) begin
      if (i != 3) begin
        pixel_x = 10'(i * 16);
        #1;
        c = time_rom_addr[10:4];
        v[4*d+:4] = (c[6:4] == 3'b011) ? c[3:0] : 4'hE;
        d--;
      end
    end
  endtask

  task automatic chk_bcd(string t, logic [15:0] e);
    logic [15:0] v;
    push(t, {16'h0, e});
    read_bcd(v);
    pop_cmp({16'h0, v});
  endtask

  task automatic chk(string t, logic [31:0] obs,
                     logic [31:0] e);
    push(t, e);
    pop_cmp(obs);
  endtask

  logic [9:0] px_tab[6] = '{0, 16, 32, 48, 64, 80};
  logic [6:0] ch_tab[6] = '{7'h30, 7'h31, 7'h32,
                            7'h2E, 7'h35, 7'h00};
  logic       on_tab[6] = '{1, 1, 1, 1, 1, 0};

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int st_cnt;
    int st_at;
    int cnt2;

    // Up mode: 11 ticks of CLK_DIV=4
    count_down = 1'b0;
    do_reset();
    chk("rst_expired", expired, 0);
    chk("rst_sectick", second_tick, 0);
    chk_bcd("rst_digits", 16'h0000);
    st_cnt = 0;
    st_at  = 0;
    for (int i = 1; i <= 44; i++) begin
      @(negedge clk);
      if (second_tick) begin
        st_cnt++;
        st_at = i;
      end
    end
    frame_tick = 1'b1;
    nclk(1);
    frame_tick = 1'b0;
    chk_bcd("up_44clk", 16'h0011);
    chk("up_expired", expired, 0);
    chk("up_st_count", st_cnt, 1);
    chk("up_st_cycle", st_at, 40);

    // Pause from prescaler=2 for 10 clocks
    do_reset();
    nclk(2);
    pause = 1'b1;
    nclk(9);
    frame_tick = 1'b1;
    nclk(1);
    frame_tick = 1'b0;
    pause = 1'b0;
    chk_bcd("pause_hold", 16'h0000);
    nclk(1);
    frame_tick = 1'b1;
    nclk(1);
    chk_bcd("snap_pretick", 16'h0000);
    nclk(1);
    frame_tick = 1'b0;
    chk_bcd("resume_tick", 16'h0001);
    nclk(4);
    chk_bcd("snap_stable", 16'h0001);

    // Down mode from 0003
    count_down = 1'b1;
    load_value = 16'h0003;
    do_reset();
    chk_bcd("dn_load", 16'h0003);
    chk("dn_rst_exp", expired, 0);
    frame_tick = 1'b1;
    nclk(5);
    chk_bcd("dn_0002", 16'h0002);
    nclk(4);
    chk_bcd("dn_0001", 16'h0001);
    nclk(3);
    chk("dn_exp_early", expired, 0);
    nclk(1);
    chk_bcd("dn_0000", 16'h0000);
    chk("dn_expired", expired, 1);
    nclk(100);
    chk_bcd("dn_held", 16'h0000);
    chk("dn_exp_held", expired, 1);
    do_reset();
    nclk(6);
    chk_bcd("dn_again", 16'h0002);
    do_reset();
    chk_bcd("dn_reload", 16'h0003);
    chk("dn_reload_exp", expired, 0);
    frame_tick = 1'b0;

    // Down mode with zero load, and digit clamp
    load_value = 16'h0000;
    do_reset();
    chk("zero_exp0", expired, 0);
    nclk(1);
    chk("zero_exp1", expired, 1);
    load_value = 16'hF0A3;
    do_reset();
    chk_bcd("clamp", 16'h9093);

    // Character layout for snapshot 0125
    load_value = 16'h0125;
    do_reset();
    pixel_y = 10'd40;
    for (int i = 0; i < 6; i++) begin
      pixel_x = px_tab[i];
      #1;
      chk($sformatf("char%0d", i),
          time_rom_addr[10:4], ch_tab[i]);
      chk($sformatf("on%0d", i), time_on, on_tab[i]);
    end
    pixel_x = 10'd16;
    #1;
    chk("rom_addr", time_rom_addr, 11'h314);
    pixel_x = 10'd22;
    #1;
    chk("bit_addr", time_bit_addr, 3);
    pixel_y = 10'd0;
    #1;
    chk("row_off", time_on, 0);

    // Two-digit up counter saturates at 99
    @(negedge clk);
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    cnt2 = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (st2) cnt2++;
    end
    frame_tick = 1'b1;
    nclk(1);
    frame_tick = 1'b0;
    pixel_y = 10'd40;
    pixel_x = 10'd0;
    #1;
    chk("sat_msd", rom2[10:4], 7'h39);
    pixel_x = 10'd16;
    #1;
    chk("sat_lsd", rom2[10:4], 7'h39);
    pixel_x = 10'd32;
    #1;
    chk("sat_on_edge", on2, 0);
    chk("sat_expired", exp2, 1);
    chk("sat_st_count", cnt2, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
